// File: rtl/wb_bridge_pkg.sv
// wb_bridge_pkg: shared state encoding, LFSR and Wishbone width constants for the latency bridge.
package wb_bridge_pkg;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, RESP} state_t;
endpackage

// File: rtl/wb_latency_bridge_lfsr16.sv
// lfsr16: 16-bit Galois LFSR (taps 16,14,13,11), advances only when enabled.
module lfsr16
  import wb_bridge_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= SEED;
    else if (en) q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
endmodule

// File: rtl/wb_latency_bridge.sv
// wb_latency_bridge: Wishbone classic bridge inserting fixed or LFSR-random wait states, with timeout error.
module wb_latency_bridge
  import wb_bridge_pkg::*;
#(
  parameter int              WAIT_CYCLES = 2,
  parameter int              RANDOM_WAIT = 0,
  parameter logic [15:0]     LFSR_SEED   = 16'hACE1,
  parameter int              TIMEOUT     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_cyc_i,
  input  logic          s_stb_i,
  input  logic          s_we_i,
  input  logic [SW-1:0] s_sel_i,
  input  logic [AW-1:0] s_adr_i,
  input  logic [DW-1:0] s_dat_i,
  output logic          s_ack_o,
  output logic          s_err_o,
  output logic [DW-1:0] s_dat_o,
  output logic          m_cyc_o,
  output logic          m_stb_o,
  output logic          m_we_o,
  output logic [SW-1:0] m_sel_o,
  output logic [AW-1:0] m_adr_o,
  output logic [DW-1:0] m_dat_o,
  input  logic          m_ack_i,
  input  logic [DW-1:0] m_dat_i
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t            state;
  logic [3:0]        wcnt;
  logic [TW-1:0]     tcnt;
  logic              live, ack_r, err_r, accept, live_n;
  logic [3:0]        load;
  logic [LFSR_W-1:0] lfsr;
  assign accept = state == IDLE && s_cyc_i && s_stb_i;
  assign load = RANDOM_WAIT != 0 ? lfsr[3:0] : 4'(WAIT_CYCLES);
  assign live_n = live && s_cyc_i;
  // A master that drops cyc has abandoned the transaction, so its response is never shown.
  assign s_ack_o = ack_r && s_cyc_i;
  assign s_err_o = err_r && s_cyc_i;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .en(accept), .q(lfsr));
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      wcnt    <= '0;
      tcnt    <= '0;
      live    <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      s_dat_o <= '0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
    end else
      unique case (state)
        IDLE: if (accept) begin
          m_we_o  <= s_we_i;
          m_sel_o <= s_sel_i;
          m_adr_o <= s_adr_i;
          m_dat_o <= s_dat_i;
          wcnt    <= load;
          tcnt    <= '0;
          live    <= 1'b1;
          state   <= load != 0 ? WAIT : ISSUE;
          m_cyc_o <= load == 0;
          m_stb_o <= load == 0;
        end
        WAIT: if (!s_cyc_i) state <= IDLE;
        else begin
          wcnt    <= wcnt - 4'd1;
          state   <= wcnt == 4'd1 ? ISSUE : WAIT;
          m_cyc_o <= wcnt == 4'd1;
          m_stb_o <= wcnt == 4'd1;
        end
        ISSUE: begin
          live <= live_n;
          if (m_ack_i) begin
            s_dat_o <= m_dat_i;
            ack_r   <= live_n;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            state   <= RESP;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            err_r   <= live_n;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            state   <= RESP;
          end else tcnt <= tcnt + 1'b1;
        end
        RESP: begin
          ack_r <= 1'b0;
          err_r <= 1'b0;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_wb_latency_bridge.sv
// tb_wb_latency_bridge: directed vectors for a fixed-wait bridge and an LFSR-wait bridge, each behind a small memory.
module tb_wb_latency_bridge;
  logic clk = 0, rst = 1;
  logic cyc_f = 0, cyc_r = 0, s_we = 0;
  logic [3:0] s_sel = 0;
  logic [29:0] s_adr = 0;
  logic [31:0] s_dat = 0;
  logic ack_f, err_f, mcyc_f, mstb_f, mwe_f, mack_f;
  logic ack_r, err_r, mcyc_r, mstb_r, mwe_r, mack_r;
  logic [31:0] sdat_f, mdat_f, sdat_r, mdat_r, min_f, min_r;
  logic [3:0] msel_f, msel_r;
  logic [29:0] madr_f, madr_r;
  logic [31:0] mem_f[16], mem_r[16];
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  wb_latency_bridge #(.WAIT_CYCLES(3), .RANDOM_WAIT(0), .TIMEOUT(8)) u_fix (
    .clk(clk), .rst(rst), .s_cyc_i(cyc_f), .s_stb_i(cyc_f), .s_we_i(s_we), .s_sel_i(s_sel),
    .s_adr_i(s_adr), .s_dat_i(s_dat), .s_ack_o(ack_f), .s_err_o(err_f), .s_dat_o(sdat_f),
    .m_cyc_o(mcyc_f), .m_stb_o(mstb_f), .m_we_o(mwe_f), .m_sel_o(msel_f), .m_adr_o(madr_f),
    .m_dat_o(mdat_f), .m_ack_i(mack_f), .m_dat_i(min_f));

  wb_latency_bridge #(.WAIT_CYCLES(2), .RANDOM_WAIT(1), .LFSR_SEED(16'hACE1), .TIMEOUT(8)) u_rnd (
    .clk(clk), .rst(rst), .s_cyc_i(cyc_r), .s_stb_i(cyc_r), .s_we_i(s_we), .s_sel_i(s_sel),
    .s_adr_i(s_adr), .s_dat_i(s_dat), .s_ack_o(ack_r), .s_err_o(err_r), .s_dat_o(sdat_r),
    .m_cyc_o(mcyc_r), .m_stb_o(mstb_r), .m_we_o(mwe_r), .m_sel_o(msel_r), .m_adr_o(madr_r),
    .m_dat_o(mdat_r), .m_ack_i(mack_r), .m_dat_i(min_r));

  // Memory decoder: address 0 is unmapped, everything else folds onto 16 words.
  assign mack_f = mcyc_f && mstb_f && madr_f != 0;
  assign mack_r = mcyc_r && mstb_r && madr_r != 0;
  assign min_f = mem_f[madr_f[3:0]];
  assign min_r = mem_r[madr_r[3:0]];

  always @(posedge clk)
    if (rst)
      for (int i = 0; i < 16; i++) begin
        mem_f[i] <= {4'(i), 28'h0000013};
        mem_r[i] <= {4'(i), 28'h0000013};
      end
    else begin
      for (int b = 0; b < 4; b++) begin
        if (mack_f && mwe_f && msel_f[b]) mem_f[madr_f[3:0]][8*b+:8] <= mdat_f[8*b+:8];
        if (mack_r && mwe_r && msel_r[b]) mem_r[madr_r[3:0]][8*b+:8] <= mdat_r[8*b+:8];
      end
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run(input bit r, input logic we, input logic [29:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, output int lat, output int stbs, output bit ack,
                     output bit err, output logic [31:0] rd, output bit fld_ok);
    @(negedge clk);
    s_we = we; s_adr = adr; s_sel = sel; s_dat = dat;
    if (r) cyc_r = 1; else cyc_f = 1;
    lat = 0; stbs = 0; ack = 0; err = 0; fld_ok = 1; rd = 0;
    while (!ack && !err && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin s_adr = ~adr; s_dat = ~dat; s_we = ~we; s_sel = ~sel; end
      if (r ? mstb_r : mstb_f) begin
        stbs++;
        if ((r ? madr_r : madr_f) != adr || (r ? mdat_r : mdat_f) != dat ||
            (r ? mwe_r : mwe_f) != we || (r ? msel_r : msel_f) != sel) fld_ok = 0;
      end
      ack = r ? ack_r : ack_f;
      err = r ? err_r : err_f;
      rd  = r ? sdat_r : sdat_f;
    end
    cyc_r = 0; cyc_f = 0;
  endtask

  typedef struct {
    logic we; logic [29:0] adr; logic [3:0] sel; logic [31:0] dat;
    int lat; int stbs; bit ack; bit err; logic [31:0] rd;
  } vec_t;
  vec_t v[7];

  initial begin
    int lat, stbs;
    bit ack, err, ok;
    logic [31:0] rd;
    logic [15:0] m;
    bit seen;
    v[0] = '{0, 30'h0010_0000, 4'hF, 32'h0, 5, 1, 1, 0, 32'h0000_0013};
    v[1] = '{1, 30'h2000_0000, 4'b0011, 32'hDEADBEEF, 5, 1, 1, 0, 32'h0000_0013};
    v[2] = '{0, 30'h2000_0000, 4'hF, 32'h0, 5, 1, 1, 0, 32'h0000_BEEF};
    v[3] = '{0, 30'h0, 4'hF, 32'h0, 12, 8, 0, 1, 32'h0000_BEEF};
    v[4] = '{0, 30'h5, 4'hF, 32'h0, 5, 1, 1, 0, 32'h5000_0013};
    v[5] = '{1, 30'h7, 4'b1100, 32'hCAFE1234, 5, 1, 1, 0, 32'h7000_0013};
    v[6] = '{0, 30'h7, 4'hF, 32'h0, 5, 1, 1, 0, 32'hCAFE_0013};

    repeat (2) @(negedge clk);
    chk("reset_fix", {ack_f, err_f, mcyc_f, mstb_f, mwe_f, msel_f, |madr_f, |mdat_f, |sdat_f}, 0);
    chk("reset_rnd", {ack_r, err_r, mcyc_r, mstb_r, mwe_r, msel_r, |madr_r, |mdat_r, |sdat_r}, 0);
    rst = 0;

    for (int i = 0; i < 7; i++) begin
      run(0, v[i].we, v[i].adr, v[i].sel, v[i].dat, lat, stbs, ack, err, rd, ok);
      chk($sformatf("v%0d_lat", i), lat, v[i].lat);
      chk($sformatf("v%0d_stbs", i), stbs, v[i].stbs);
      chk($sformatf("v%0d_ackerr", i), {ack, err}, {v[i].ack, v[i].err});
      chk($sformatf("v%0d_rd", i), rd, v[i].rd);
      chk($sformatf("v%0d_fields", i), ok, 1);
    end

    // Abort during WAIT at cycle 2, then a fresh request in cycle 3 must see normal latency.
    @(negedge clk);
    s_we = 0; s_adr = 30'h9; s_sel = 4'hF; cyc_f = 1;
    seen = 0;
    repeat (2) begin @(negedge clk); seen |= mcyc_f | ack_f | err_f; end
    cyc_f = 0;
    chk("abort_wait_quiet", seen, 0);
    run(0, 0, 30'h5, 4'hF, 0, lat, stbs, ack, err, rd, ok);
    chk("abort_wait_next_lat", lat, 5);
    chk("abort_wait_next_stbs", stbs, 1);
    chk("abort_wait_next_rd", rd, 32'h5000_0013);

    // Abort during ISSUE of a write: memory still updated, no upstream response.
    @(negedge clk);
    s_we = 1; s_adr = 30'h3; s_sel = 4'hF; s_dat = 32'h1234_5678; cyc_f = 1;
    repeat (4) @(negedge clk);
    chk("abort_issue_stb", mstb_f, 1);
    cyc_f = 0;
    seen = 0;
    repeat (3) begin @(negedge clk); seen |= ack_f | err_f | mcyc_f; end
    chk("abort_issue_noresp", seen, 0);
    chk("abort_issue_commit", mem_f[3], 32'h1234_5678);

    // LFSR-driven waits: latency must follow the model LFSR, which steps once per request.
    m = 16'hACE1;
    for (int i = 0; i < 100; i++) begin
      logic [29:0] a;
      a = 30'(i % 15 + 1);
      run(1, 0, a, 4'hF, 0, lat, stbs, ack, err, rd, ok);
      chk($sformatf("rnd%0d_lat", i), lat, 32'(m[3:0]) + 2);
      chk($sformatf("rnd%0d_rd", i), rd, {a[3:0], 28'h0000013});
      m = (m >> 1) ^ (m[0] ? 16'hB400 : 16'h0);
    end

    // Reset while stuck in ISSUE on the unmapped address.
    @(negedge clk);
    s_we = 0; s_adr = 30'h0; s_sel = 4'hF; cyc_f = 1;
    repeat (6) @(negedge clk);
    chk("rst_issue_pre", mstb_f, 1);
    rst = 1; cyc_f = 0;
    @(negedge clk);
    chk("rst_issue_zero", {ack_f, err_f, mcyc_f, mstb_f, mwe_f, msel_f, |madr_f, |mdat_f, |sdat_f}, 0);
    rst = 0;
    run(0, 0, 30'h5, 4'hF, 0, lat, stbs, ack, err, rd, ok);
    chk("rst_after_lat", lat, 5);
    chk("rst_after_ackerr", {ack, err}, 2'b10);
    chk("rst_after_rd", rd, 32'h5000_0013);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_latency_bridge.md
WB_LATENCY_BRIDGE -- requirements
Module: wb_latency_bridge

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, fixed wait states inserted before each downstream cycle (0..15).
REQ-002 Parameter RANDOM_WAIT, default 0; when 1, per-request wait count comes from the LFSR instead of WAIT_CYCLES.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-004 Parameter TIMEOUT, default 8, ISSUE cycles without downstream ack before error.
REQ-005 clk  input  1  single clock; all state changes on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 s_cyc_i, s_stb_i, s_we_i  input  1 each  upstream Wishbone classic request from core.
REQ-008 s_sel_i  input  4, s_adr_i  input  30 (word address), s_dat_i  input  32  upstream request fields.
REQ-009 s_ack_o, s_err_o  output  1 each; s_dat_o  output  32  upstream response.
REQ-010 m_cyc_o, m_stb_o, m_we_o  output  1 each; m_sel_o  output  4; m_adr_o  output  30; m_dat_o  output  32  downstream request to memory decoder.
REQ-011 m_ack_i  input  1; m_dat_i  input  32  downstream combinational response.

Function
REQ-012 States: IDLE, WAIT, ISSUE, RESP.
REQ-013 IDLE: on s_cyc_i&&s_stb_i, register we/sel/adr/dat, load wait counter; go WAIT if count>0, else ISSUE.
REQ-014 WAIT: decrement counter each cycle; at count reaching 0 go ISSUE.
REQ-015 ISSUE: drive m_cyc_o=m_stb_o=1 with registered fields; if m_ack_i, capture m_dat_i into s_dat_o register, go RESP with ack flag.
REQ-016 ISSUE without m_ack_i: stay, increment timeout counter; after TIMEOUT cycles go RESP with error flag; downstream strobes drop.
REQ-017 RESP: exactly one cycle of s_ack_o (or s_err_o, never both), then IDLE.
REQ-018 Latency: request first sampled in IDLE at cycle 0, wait count N, immediate downstream ack -> s_ack_o high in cycle N+2.
REQ-019 Request sampled in RESP cycle is ignored; next acceptance no earlier than first IDLE cycle.
REQ-020 s_dat_o holds last captured read data until next capture; undefined-free (reset 0).
REQ-021 Abort: s_cyc_i low during WAIT -> IDLE, no downstream cycle issued.
REQ-022 Abort: s_cyc_i low during ISSUE/RESP -> downstream cycle completes (writes commit), s_ack_o/s_err_o suppressed, return IDLE.
REQ-023 Request fields are not re-sampled after acceptance; upstream changes mid-transaction do not affect m_* outputs.
REQ-024 RANDOM_WAIT=1: wait count = LFSR[3:0]; 16-bit Galois LFSR (taps 16,14,13,11) advances once per accepted request only.
REQ-025 Counters saturate-free: wait counter 4 bits, timeout counter sized to hold TIMEOUT.

Reset
REQ-026 rst high at posedge: state IDLE, all m_* outputs 0, s_ack_o=s_err_o=0, s_dat_o=0, counters 0, LFSR=LFSR_SEED.
REQ-027 Reset mid-transaction abandons it: m_cyc_o low in the cycle following reset, no upstream ack emitted.

Structure
REQ-028 Shared package wb_bridge_pkg: state enum, LFSR width/tap constant, Wishbone address/data/sel width constants.
REQ-029 One sub-module lfsr16 (enable, synchronous reset to seed, 16-bit state output).
REQ-030 Bridge instantiated between topEntity Wishbone master and the memory decode in the top-level bench.

Verification
REQ-031 WAIT_CYCLES=0, read adr 30'h0010_0000, memory returns 32'h0000_0013 -> s_ack_o at cycle 2, s_dat_o=32'h13.
REQ-032 WAIT_CYCLES=3, write adr 30'h2000_0000 sel 4'b0011 dat 32'hDEADBEEF -> m_stb_o high cycle 4, s_ack_o cycle 5, memory low half = 16'hBEEF.
REQ-033 Unmapped adr 30'h0 with TIMEOUT=8 -> m_stb_o high 8 cycles, then s_err_o one cycle, s_ack_o never.
REQ-034 WAIT_CYCLES=5, s_cyc_i dropped at cycle 2 -> m_cyc_o never asserts, bridge IDLE at cycle 3.
REQ-035 RANDOM_WAIT=1, seed 16'hACE1, 100 back-to-back reads -> every ack latency equals model LFSR[3:0]+2; data matches memory.
REQ-036 rst asserted during ISSUE -> next cycle all outputs 0, following request completes normally.
